// File: rtl/vector_rs_issue.sv
// Vector reservation station and issue stage: holds decoded vector ops, tracks
// per-group operand readiness and issues one (entry, group) beat per cycle, oldest-ready first.
module vector_rs_issue #(
    parameter int unsigned RS_SIZE = 4,
    parameter int unsigned TAG_W   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [6:0]       alloc_opcode,
    input  logic [8:0]       alloc_func,
    input  logic [4:0]       alloc_dest,
    input  logic [4:0]       alloc_src1,
    input  logic [4:0]       alloc_src2,
    input  logic [3:0]       alloc_src1_busy,
    input  logic [3:0]       alloc_src2_busy,
    input  logic             wb_v_valid,
    input  logic [4:0]       wb_v_reg,
    input  logic [1:0]       wb_v_group,
    input  logic             wb_s_valid,
    input  logic [4:0]       wb_s_reg,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [6:0]       iss_opcode,
    output logic [8:0]       iss_func,
    output logic [4:0]       iss_dest,
    output logic [4:0]       iss_src1,
    output logic [4:0]       iss_src2,
    output logic [1:0]       iss_group,
    output logic             iss_last,
    output logic [TAG_W-1:0] iss_tag,
    output logic [TAG_W:0]   rs_count,
    output logic             rs_full
);

    localparam int unsigned CNT_W   = TAG_W + 1;
    localparam logic [6:0]  OP_LOAD = 7'b0000111;
    localparam logic [6:0]  OP_VARITH = 7'b1010111;

    logic [RS_SIZE-1:0] valid_q;
    logic [6:0]         opcode_q  [RS_SIZE];
    logic [8:0]         func_q    [RS_SIZE];
    logic [4:0]         dest_q    [RS_SIZE];
    logic [4:0]         src1_q    [RS_SIZE];
    logic [4:0]         src2_q    [RS_SIZE];
    logic [3:0]         s1_busy_q [RS_SIZE];
    logic [3:0]         s2_busy_q [RS_SIZE];
    logic [1:0]         grp_q     [RS_SIZE];
    // older_q[i][j] set means entry j was allocated before entry i
    logic [RS_SIZE-1:0] older_q   [RS_SIZE];
    logic [CNT_W-1:0]   count_q;
    logic               lock_q;
    logic [TAG_W-1:0]   lock_tag_q;

    logic [RS_SIZE-1:0] rdy;
    logic               sel_any;
    logic [TAG_W-1:0]   sel_tag;
    logic [TAG_W-1:0]   free_idx;
    logic               free_found;
    logic               new_vec;
    logic [3:0]         new_s1_busy;
    logic [3:0]         new_s2_busy;
    logic               alloc_fire;
    logic               iss_fire;
    logic               last_fire;

    // Only add (funct3 000) reads a vector src1; load, store and sub read a scalar.
    function automatic logic vec_src1(input logic [6:0] op, input logic [8:0] fn);
        return (op == OP_VARITH) && (fn[2:0] == 3'b000);
    endfunction

    // Per-entry readiness of the entry's next group
    always_comb begin
        rdy = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            rdy[i] = valid_q[i] && !s2_busy_q[i][grp_q[i]] &&
                     (vec_src1(opcode_q[i], func_q[i]) ? !s1_busy_q[i][grp_q[i]]
                                                       : (s1_busy_q[i] == 4'b0000));
        end
    end

    // Oldest ready entry wins unless a stalled beat holds the selection
    always_comb begin
        sel_any = 1'b0;
        sel_tag = '0;
        if (lock_q) begin
            sel_any = 1'b1;
            sel_tag = lock_tag_q;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (rdy[i] && ((older_q[i] & rdy) == '0)) begin
                    sel_any = 1'b1;
                    sel_tag = TAG_W'(i);
                end
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = TAG_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // Incoming entry sees same-cycle writebacks so no wakeup is lost
    always_comb begin
        new_vec     = vec_src1(alloc_opcode, alloc_func);
        new_s1_busy = alloc_src1_busy;
        new_s2_busy = (alloc_opcode == OP_LOAD) ? 4'b0000 : alloc_src2_busy;
        if (wb_v_valid && new_vec && (alloc_src1 == wb_v_reg)) new_s1_busy[wb_v_group] = 1'b0;
        if (wb_s_valid && !new_vec && (alloc_src1 == wb_s_reg)) new_s1_busy = 4'b0000;
        if (wb_v_valid && (alloc_src2 == wb_v_reg)) new_s2_busy[wb_v_group] = 1'b0;
    end

    assign rs_count    = count_q;
    assign rs_full     = (count_q == CNT_W'(RS_SIZE));
    assign alloc_ready = !rs_full;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign iss_valid  = sel_any;
    assign iss_tag    = sel_any ? sel_tag : '0;
    assign iss_group  = sel_any ? grp_q[sel_tag] : 2'b00;
    assign iss_last   = sel_any && (grp_q[sel_tag] == 2'd3);
    assign iss_opcode = sel_any ? opcode_q[sel_tag] : 7'b0;
    assign iss_func   = sel_any ? func_q[sel_tag] : 9'b0;
    assign iss_dest   = sel_any ? dest_q[sel_tag] : 5'b0;
    assign iss_src1   = sel_any ? src1_q[sel_tag] : 5'b0;
    assign iss_src2   = sel_any ? src2_q[sel_tag] : 5'b0;
    assign iss_fire   = iss_valid && iss_ready;
    assign last_fire  = iss_fire && (grp_q[sel_tag] == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_tag_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                opcode_q[i]  <= '0;
                func_q[i]    <= '0;
                dest_q[i]    <= '0;
                src1_q[i]    <= '0;
                src2_q[i]    <= '0;
                s1_busy_q[i] <= '0;
                s2_busy_q[i] <= '0;
                grp_q[i]     <= '0;
                older_q[i]   <= '0;
            end
        end else begin
            // Wakeups for groups already issued are dropped
            for (int i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && wb_v_valid && (wb_v_group >= grp_q[i])) begin
                    if (vec_src1(opcode_q[i], func_q[i]) && (src1_q[i] == wb_v_reg))
                        s1_busy_q[i][wb_v_group] <= 1'b0;
                    if (src2_q[i] == wb_v_reg)
                        s2_busy_q[i][wb_v_group] <= 1'b0;
                end
                if (valid_q[i] && wb_s_valid && !vec_src1(opcode_q[i], func_q[i]) &&
                    (src1_q[i] == wb_s_reg))
                    s1_busy_q[i] <= 4'b0000;
            end

            if (iss_fire) begin
                grp_q[sel_tag] <= grp_q[sel_tag] + 2'd1;
                if (grp_q[sel_tag] == 2'd3) valid_q[sel_tag] <= 1'b0;
            end

            if (alloc_fire) begin
                valid_q[free_idx]   <= 1'b1;
                opcode_q[free_idx]  <= alloc_opcode;
                func_q[free_idx]    <= alloc_func;
                dest_q[free_idx]    <= alloc_dest;
                src1_q[free_idx]    <= alloc_src1;
                src2_q[free_idx]    <= alloc_src2;
                s1_busy_q[free_idx] <= new_s1_busy;
                s2_busy_q[free_idx] <= new_s2_busy;
                grp_q[free_idx]     <= 2'd0;
                for (int j = 0; j < RS_SIZE; j++) older_q[j][free_idx] <= 1'b0;
                older_q[free_idx]   <= valid_q;
            end

            if (alloc_fire && !last_fire)      count_q <= count_q + CNT_W'(1);
            else if (!alloc_fire && last_fire) count_q <= count_q - CNT_W'(1);

            lock_q     <= iss_valid && !iss_ready;
            lock_tag_q <= sel_tag;
        end
    end

endmodule

// File: tb/tb_vector_rs_issue.sv
// Bench for vector_rs_issue: directed scenarios plus randomized traffic checked
// against an age-ordered behavioural model of the reservation station.
module tb_vector_rs_issue;

    localparam logic [6:0] OP_LD = 7'b0000111;
    localparam logic [6:0] OP_ST = 7'b0100111;
    localparam logic [6:0] OP_V  = 7'b1010111;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid, alloc_ready;
    logic [6:0] alloc_opcode;
    logic [8:0] alloc_func;
    logic [4:0] alloc_dest, alloc_src1, alloc_src2;
    logic [3:0] alloc_src1_busy, alloc_src2_busy;
    logic       wb_v_valid;
    logic [4:0] wb_v_reg;
    logic [1:0] wb_v_group;
    logic       wb_s_valid;
    logic [4:0] wb_s_reg;
    logic       iss_valid, iss_ready;
    logic [6:0] iss_opcode;
    logic [8:0] iss_func;
    logic [4:0] iss_dest, iss_src1, iss_src2;
    logic [1:0] iss_group;
    logic       iss_last;
    logic [1:0] iss_tag;
    logic [2:0] rs_count;
    logic       rs_full;

    int total = 0;
    int bad   = 0;

    vector_rs_issue #(.RS_SIZE(4), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_opcode(alloc_opcode), .alloc_func(alloc_func), .alloc_dest(alloc_dest),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .alloc_src1_busy(alloc_src1_busy), .alloc_src2_busy(alloc_src2_busy),
        .wb_v_valid(wb_v_valid), .wb_v_reg(wb_v_reg), .wb_v_group(wb_v_group),
        .wb_s_valid(wb_s_valid), .wb_s_reg(wb_s_reg),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_func(iss_func), .iss_dest(iss_dest),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_group(iss_group),
        .iss_last(iss_last), .iss_tag(iss_tag), .rs_count(rs_count), .rs_full(rs_full)
    );

    always #5 clk = ~clk;

    // Reference model: entries ordered by allocation sequence number
    bit         m_v    [4];
    logic [6:0] m_op   [4];
    logic [8:0] m_fn   [4];
    logic [4:0] m_d    [4];
    logic [4:0] m_s1   [4];
    logic [4:0] m_s2   [4];
    logic [3:0] m_b1   [4];
    logic [3:0] m_b2   [4];
    int         m_g    [4];
    int         m_seq  [4];
    int         seq_ctr;
    bit         m_lock;
    int         m_lock_t;
    bit         e_valid;
    int         e_t;
    int         e_count;
    logic [35:0] e_bus;
    logic [35:0] got_bus;

    assign got_bus = {iss_valid, iss_tag, iss_group, iss_last, iss_opcode, iss_func,
                      iss_dest, iss_src1, iss_src2};

    function automatic bit m_is_vec(logic [6:0] op, logic [8:0] fn);
        return (op == OP_V) && (fn[2:0] == 3'b000);
    endfunction

    function automatic bit m_ready(int i);
        bit s1ok;
        s1ok = m_is_vec(m_op[i], m_fn[i]) ? (m_b1[i][m_g[i]] == 1'b0) : (m_b1[i] == 4'b0);
        return m_v[i] && s1ok && (m_b2[i][m_g[i]] == 1'b0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 0; m_g[i] = 0; m_seq[i] = 0;
            m_op[i] = '0; m_fn[i] = '0; m_d[i] = '0; m_s1[i] = '0; m_s2[i] = '0;
            m_b1[i] = '0; m_b2[i] = '0;
        end
        seq_ctr = 0; m_lock = 0; m_lock_t = 0;
    endtask

    task automatic model_eval();
        int best;
        best = -1;
        if (m_lock) best = m_lock_t;
        else
            for (int i = 0; i < 4; i++)
                if (m_ready(i) && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        e_valid = (best >= 0);
        e_t = best;
        if (e_valid)
            e_bus = {1'b1, 2'(best), 2'(m_g[best]), (m_g[best] == 3), m_op[best], m_fn[best],
                     m_d[best], m_s1[best], m_s2[best]};
        else
            e_bus = '0;
        e_count = 0;
        for (int i = 0; i < 4; i++) if (m_v[i]) e_count++;
    endtask

    task automatic model_update();
        int idx;
        bit af, fire, vec;
        logic [3:0] b1, b2;
        fire = e_valid && iss_ready;
        af   = alloc_valid && (e_count < 4);
        idx  = -1;
        for (int i = 0; i < 4; i++) if (!m_v[i] && idx < 0) idx = i;
        for (int i = 0; i < 4; i++) begin
            if (m_v[i]) begin
                vec = m_is_vec(m_op[i], m_fn[i]);
                if (wb_v_valid && vec && m_s1[i] == wb_v_reg) m_b1[i][wb_v_group] = 1'b0;
                if (wb_v_valid && m_s2[i] == wb_v_reg) m_b2[i][wb_v_group] = 1'b0;
                if (wb_s_valid && !vec && m_s1[i] == wb_s_reg) m_b1[i] = 4'b0;
            end
        end
        if (fire) begin
            if (m_g[e_t] == 3) m_v[e_t] = 0;
            else m_g[e_t] = m_g[e_t] + 1;
        end
        if (af) begin
            vec = m_is_vec(alloc_opcode, alloc_func);
            b1 = alloc_src1_busy;
            b2 = (alloc_opcode == OP_LD) ? 4'b0 : alloc_src2_busy;
            if (wb_v_valid && vec && alloc_src1 == wb_v_reg) b1[wb_v_group] = 1'b0;
            if (wb_s_valid && !vec && alloc_src1 == wb_s_reg) b1 = 4'b0;
            if (wb_v_valid && alloc_src2 == wb_v_reg) b2[wb_v_group] = 1'b0;
            m_v[idx] = 1; m_op[idx] = alloc_opcode; m_fn[idx] = alloc_func; m_d[idx] = alloc_dest;
            m_s1[idx] = alloc_src1; m_s2[idx] = alloc_src2; m_b1[idx] = b1; m_b2[idx] = b2;
            m_g[idx] = 0; m_seq[idx] = seq_ctr; seq_ctr++;
        end
        m_lock   = e_valid && !iss_ready;
        m_lock_t = e_t;
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_opcode = '0; alloc_func = '0; alloc_dest = '0;
        alloc_src1 = '0; alloc_src2 = '0; alloc_src1_busy = '0; alloc_src2_busy = '0;
        wb_v_valid = 0; wb_v_reg = '0; wb_v_group = '0; wb_s_valid = 0; wb_s_reg = '0;
        iss_ready = 0;
    endtask

    task automatic set_alloc(logic [6:0] op, logic [8:0] fn, logic [4:0] d, logic [4:0] s1,
                             logic [4:0] s2, logic [3:0] b1, logic [3:0] b2);
        alloc_valid = 1; alloc_opcode = op; alloc_func = fn; alloc_dest = d;
        alloc_src1 = s1; alloc_src2 = s2; alloc_src1_busy = b1; alloc_src2_busy = b2;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (iss_valid !== 1'b0 || rs_count !== 3'd0 || rs_full !== 1'b0 || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctl: valid=%0b count=%0d full=%0b ready=%0b want 0 0 0 1",
                     iss_valid, rs_count, rs_full, alloc_ready);
        end
        total++;
        if (got_bus !== 36'd0) begin
            bad++;
            $display("FAIL reset_iss: got %h want 0", got_bus);
        end
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_stream();
        do_reset();
        set_alloc(OP_V, 9'h000, 5'd3, 5'd1, 5'd2, 4'b0000, 4'b0000);
        sample();
        total++;
        if (iss_valid !== 1'b0 || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_pre: valid=%0b ready=%0b want 0 1", iss_valid, alloc_ready);
        end
        advance();
        alloc_valid = 0;
        iss_ready = 1;
        for (int k = 0; k < 4; k++) begin
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_group !== 2'(k) || iss_last !== (k == 3) ||
                iss_tag !== 2'd0 || iss_opcode !== OP_V || iss_dest !== 5'd3 || rs_count !== 3'd1) begin
                bad++;
                $display("FAIL stream_beat%0d: v=%0b g=%0d last=%0b tag=%0d op=%b dest=%0d cnt=%0d want 1 %0d %0b 0 %b 3 1",
                         k, iss_valid, iss_group, iss_last, iss_tag, iss_opcode, iss_dest, rs_count,
                         k, (k == 3), OP_V);
            end
            advance();
        end
        sample();
        total++;
        if (iss_valid !== 1'b0 || rs_count !== 3'd0) begin
            bad++;
            $display("FAIL stream_done: valid=%0b count=%0d want 0 0", iss_valid, rs_count);
        end
    endtask

    task automatic test_partial_wakeup();
        do_reset();
        set_alloc(OP_V, 9'h000, 5'd3, 5'd1, 5'd2, 4'b1100, 4'b0000);
        advance();
        alloc_valid = 0;
        iss_ready = 1;
        for (int g = 0; g < 4; g++) begin
            if (g >= 2) begin
                sample();
                total++;
                if (iss_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL partial_stall%0d: valid=%0b want 0", g, iss_valid);
                end
                wb_v_valid = 1; wb_v_reg = 5'd1; wb_v_group = 2'(g);
                advance();
                wb_v_valid = 0;
            end
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_group !== 2'(g) || iss_last !== (g == 3)) begin
                bad++;
                $display("FAIL partial_beat%0d: v=%0b g=%0d last=%0b want 1 %0d %0b",
                         g, iss_valid, iss_group, iss_last, g, (g == 3));
            end
            advance();
        end
        sample();
        total++;
        if (rs_count !== 3'd0 || iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL partial_done: count=%0d valid=%0b want 0 0", rs_count, iss_valid);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_alloc(OP_V, 9'h000, 5'(10 + k), 5'd1, 5'(4 + k), 4'b0000, 4'b1111);
            sample();
            total++;
            if (alloc_ready !== 1'b1) begin
                bad++;
                $display("FAIL full_fill%0d: ready=%0b want 1", k, alloc_ready);
            end
            advance();
        end
        set_alloc(OP_V, 9'h000, 5'd20, 5'd1, 5'd8, 4'b0000, 4'b1111);
        iss_ready = 1;
        for (int k = 0; k < 2; k++) begin
            sample();
            total++;
            if (rs_full !== 1'b1 || alloc_ready !== 1'b0 || rs_count !== 3'd4 || iss_valid !== 1'b0) begin
                bad++;
                $display("FAIL full_hold%0d: full=%0b ready=%0b count=%0d valid=%0b want 1 0 4 0",
                         k, rs_full, alloc_ready, rs_count, iss_valid);
            end
            advance();
        end
        for (int g = 0; g < 4; g++) begin
            wb_v_valid = 1; wb_v_reg = 5'd4; wb_v_group = 2'(g);
            advance();
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_tag !== 2'd0 || iss_group !== 2'(g) || alloc_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_drain%0d: v=%0b tag=%0d g=%0d ready=%0b want 1 0 %0d 0",
                         g, iss_valid, iss_tag, iss_group, alloc_ready, g);
            end
        end
        wb_v_valid = 0;
        advance();
        sample();
        total++;
        if (alloc_ready !== 1'b1 || rs_full !== 1'b0 || rs_count !== 3'd3) begin
            bad++;
            $display("FAIL full_free: ready=%0b full=%0b count=%0d want 1 0 3", alloc_ready, rs_full, rs_count);
        end
        advance();
        alloc_valid = 0;
        sample();
        total++;
        if (rs_count !== 3'd4) begin
            bad++;
            $display("FAIL full_refill: count=%0d want 4", rs_count);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        set_alloc(OP_LD, 9'h005, 5'd4, 5'd5, 5'd6, 4'b1111, 4'b1111);
        wb_s_valid = 1; wb_s_reg = 5'd5;
        iss_ready = 1;
        advance();
        alloc_valid = 0; wb_s_valid = 0;
        for (int g = 0; g < 4; g++) begin
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_group !== 2'(g) || iss_opcode !== OP_LD || iss_src1 !== 5'd5) begin
                bad++;
                $display("FAIL bypass_beat%0d: v=%0b g=%0d op=%b src1=%0d want 1 %0d %b 5",
                         g, iss_valid, iss_group, iss_opcode, iss_src1, g, OP_LD);
            end
            advance();
        end
    endtask

    task automatic test_order_lock();
        int et, eg;
        do_reset();
        set_alloc(OP_V, 9'h000, 5'd10, 5'd1, 5'd2, 4'b0000, 4'b0001);
        advance();
        set_alloc(OP_V, 9'h000, 5'd11, 5'd1, 5'd3, 4'b0000, 4'b0000);
        sample();
        total++;
        if (iss_valid !== 1'b0) begin
            bad++;
            $display("FAIL order_a_blocked: valid=%0b want 0", iss_valid);
        end
        advance();
        alloc_valid = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) iss_ready = 1;
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_tag !== 2'd1 || iss_group !== 2'd0 ||
                iss_src2 !== 5'd3 || iss_dest !== 5'd11) begin
                bad++;
                $display("FAIL lock_hold%0d: v=%0b tag=%0d g=%0d src2=%0d dest=%0d want 1 1 0 3 11",
                         c, iss_valid, iss_tag, iss_group, iss_src2, iss_dest);
            end
            if (c == 0) begin wb_v_valid = 1; wb_v_reg = 5'd2; wb_v_group = 2'd0; end
            advance();
            wb_v_valid = 0;
        end
        for (int k = 0; k < 7; k++) begin
            et = (k < 4) ? 0 : 1;
            eg = (k < 4) ? k : k - 3;
            sample();
            total++;
            if (iss_valid !== 1'b1 || iss_tag !== 2'(et) || iss_group !== 2'(eg)) begin
                bad++;
                $display("FAIL order_beat%0d: v=%0b tag=%0d g=%0d want 1 %0d %0d",
                         k, iss_valid, iss_tag, iss_group, et, eg);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_alloc(OP_V, 9'h000, 5'd3, 5'd1, 5'd2, 4'b0000, 4'b0000);
        iss_ready = 1;
        advance();
        set_alloc(OP_ST, 9'h000, 5'd4, 5'd7, 5'd2, 4'b0000, 4'b0000);
        advance();
        alloc_valid = 0;
        sample();
        total++;
        if (iss_valid !== 1'b1 || rs_count !== 3'd2) begin
            bad++;
            $display("FAIL midrst_pre: valid=%0b count=%0d want 1 2", iss_valid, rs_count);
        end
        rst = 1;
        #1;
        total++;
        if (iss_valid !== 1'b0 || rs_count !== 3'd0 || alloc_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_now: valid=%0b count=%0d ready=%0b want 0 0 1",
                     iss_valid, rs_count, alloc_ready);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        iss_ready = 1;
        for (int c = 0; c < 4; c++) begin
            sample();
            total++;
            if (iss_valid !== 1'b0) begin
                bad++;
                $display("FAIL midrst_after%0d: valid=%0b want 0", c, iss_valid);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [6:0] op;
        logic [8:0] fn;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 3))
                0: op = OP_LD;
                1: op = OP_ST;
                default: op = OP_V;
            endcase
            fn = 9'($urandom);
            if (op == OP_V) fn[2:0] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b100;
            alloc_valid     = ($urandom_range(0, 2) == 0);
            alloc_opcode    = op;
            alloc_func      = fn;
            alloc_dest      = 5'($urandom);
            alloc_src1      = 5'($urandom_range(0, 3));
            alloc_src2      = 5'($urandom_range(0, 3));
            alloc_src1_busy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            alloc_src2_busy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            wb_v_valid      = ($urandom_range(0, 1) == 0);
            wb_v_reg        = 5'($urandom_range(0, 3));
            wb_v_group      = 2'($urandom);
            wb_s_valid      = ($urandom_range(0, 3) == 0);
            wb_s_reg        = 5'($urandom_range(0, 3));
            iss_ready       = ($urandom_range(0, 9) < 7);
            sample();
            total++;
            if (got_bus !== e_bus) begin
                bad++;
                $display("FAIL rand_iss c=%0d: got %h want %h", c, got_bus, e_bus);
            end
            total++;
            if (rs_count !== 3'(e_count) || rs_full !== (e_count == 4) || alloc_ready !== (e_count < 4)) begin
                bad++;
                $display("FAIL rand_cnt c=%0d: count=%0d full=%0b ready=%0b want count=%0d",
                         c, rs_count, rs_full, alloc_ready, e_count);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_partial_wakeup();
        test_full();
        test_bypass();
        test_order_lock();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_rs_issue.md
Name: vector_rs_issue

Overview:
- Vector reservation station and issue stage. Sits directly downstream of decode, which allocates vector load, store and add/sub entries into it.
- Holds entries until their operands are ready, one 8-element group at a time. Tracks per-group source readiness using the 4-bit busy masks produced by decode, and wakes entries on vector and scalar writeback.
- Issues one (entry, group) beat per cycle to the vector execution lanes, oldest-ready first.

Parameters:
- RS_SIZE, 4, number of vector RS entries (power of 2, 2..16)
- TAG_W, 2, width of the entry index; equals log2(RS_SIZE)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- alloc_valid  in  1  decode presents an instruction
- alloc_ready  out  1  entry available; allocation fires on alloc_valid && alloc_ready
- alloc_opcode  in  7  0000111 load, 0100111 store, 1010111 add/sub
- alloc_func  in  9  {funct6, funct3}; funct3 000 is add (vector src1), 100 is sub (scalar src1)
- alloc_dest  in  5  vector destination register
- alloc_src1  in  5  src1 register (scalar for load/store/sub, vector for add)
- alloc_src2  in  5  vector src2 register (unused for load)
- alloc_src1_busy  in  4  bit g = 1 means group g of src1 is not ready
- alloc_src2_busy  in  4  same encoding for src2
- wb_v_valid  in  1  vector writeback of one group
- wb_v_reg  in  5  register written
- wb_v_group  in  2  group index written
- wb_s_valid  in  1  scalar writeback
- wb_s_reg  in  5  scalar register written
- iss_valid  out  1  issue beat valid
- iss_ready  in  1  execution lane accepts; the beat fires on iss_valid && iss_ready
- iss_opcode, iss_func, iss_dest, iss_src1, iss_src2  out  7/9/5/5/5  fields of the issuing entry
- iss_group  out  2  group being issued
- iss_last  out  1  iss_group == 3
- iss_tag  out  TAG_W  index of the issuing entry
- rs_count  out  TAG_W+1  number of valid entries
- rs_full  out  1  rs_count == RS_SIZE

Behaviour:
- Reset (async): all entries invalid, all group counters 0, selection lock cleared.
  - iss_valid=0, rs_count=0, rs_full=0, alloc_ready=1.
  - All other iss_* outputs = 0.
- Entry state: valid, fields, src1_busy[3:0], src2_busy[3:0], next-group counter g (2 bits), age row.
- Allocation:
  - alloc_ready = !rs_full, computed from registered count only. An entry freed this cycle cannot be reused until the next cycle.
  - The lowest-index free entry is written, with g=0.
  - Load: src2_busy is forced to 0000 on write.
  - Age matrix: on allocation of entry i, set older[i][j] = 1 for every currently valid j; clear older[j][i] for all j.
- Operand readiness for group g:
  - src1: scalar operand (load, store, sub) → ready when src1_busy == 0000. Vector operand (add) → ready when src1_busy[g] == 0.
  - src2: ready when src2_busy[g] == 0.
- Wakeup:
  - wb_v_valid clears src1_busy[wb_v_group] in every valid entry with a vector src1 equal to wb_v_reg. It clears src2_busy[wb_v_group] in every valid entry with src2 equal to wb_v_reg. src1 and src2 naming the same register are both cleared.
  - wb_s_valid clears all four src1_busy bits in every valid entry with a scalar src1 equal to wb_s_reg.
  - Wakeups also apply to the allocation being written in the same cycle (bypass); no wakeup may be lost.
- Selection and issue:
  - iss_* outputs are combinational from the selected entry.
  - Selected entry = the ready entry with no older ready entry.
  - Minimum latency: allocated at edge N, issue beat visible in cycle N+1 if ready.
  - While iss_valid && !iss_ready, the selection is locked. The tag, group and all fields stay stable, even if an older entry becomes ready or wakeups occur.
  - On fire: the entry's g increments. If g was 3, the entry is invalidated and rs_count decrements.
  - The same entry may issue its next group in the next cycle, giving 1 beat/cycle throughput.
- Simultaneous allocation and free in one cycle: rs_count unchanged.
- Writeback for a group already issued: ignored; no effect on stored state.

Test Plan:
- RS_SIZE=4; alloc add (func 000), src1=1, src2=2, both busy=0000 → 4 consecutive beats, iss_group 0,1,2,3, iss_last only on group 3; rs_count returns to 0 the cycle after the last beat.
- Alloc add with src1_busy=1100 → groups 0 and 1 issue, then iss_valid=0. wb_v reg=1 group=2 → group 2 issues the next cycle, then stall. wb_v reg=1 group=3 → group 3 issues.
- Allocate 4 entries with src2_busy=1111 → rs_full=1, alloc_ready=0, and a 5th alloc_valid is held. wb_v frees the oldest entry after its 4 beats → alloc_ready=1 the following cycle.
- Load with src1=5, src1_busy=1111 and wb_s reg=5 in the same cycle as allocation → entry issues group 0 the next cycle (bypass verified).
- Entries A (older) and B both ready → A's 4 beats precede B's. With iss_ready held 0 for 3 cycles while B is selected and A becomes ready → tag, group and fields stay stable on B until fire.
- Assert rst mid-issue, with 2 entries valid and iss_valid=1 → iss_valid=0 and rs_count=0 immediately, alloc_ready=1; no beats after reset release.
